// File: rtl/fp32_pkg.sv
// Shared FP32 field layout, constants and FSM states for the FP32 -> int32 converter.
package fp32_pkg;

   localparam int FP32_BIAS = 127;
   localparam logic [7:0] FP32_EXP_SPECIAL = 8'hFF;

   localparam int SIGN_BIT = 31;
   localparam int EXP_W    = 8;
   localparam int EXP_LSB  = 23;
   localparam int FRAC_W   = 23;
   localparam int MAG_W    = 32;
   localparam int CNT_W    = 6;

   // Shift distance that pushes every significand bit past the guard position.
   localparam logic [CNT_W-1:0] CNT_FLUSH = 6'd33;

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH, HOLD} state_t;

endpackage

// File: rtl/fp_shift_sticky.sv
// Right shift of {mag, guard, sticky} by 0..SHIFT_STEP positions in one cycle.
module fp_shift_sticky
   import fp32_pkg::*;
#(
   parameter int SHIFT_STEP = 1
) (
   input  logic [MAG_W-1:0] mag_in,
   input  logic             guard_in,
   input  logic             sticky_in,
   input  logic [CNT_W-1:0] step,
   output logic [MAG_W-1:0] mag_out,
   output logic             guard_out,
   output logic             sticky_out
);

   always_comb begin
      mag_out    = mag_in;
      guard_out  = guard_in;
      sticky_out = sticky_in;
      // Each single-bit step retires the old guard into sticky.
      for (int i = 1; i <= SHIFT_STEP; i++) begin
         if (CNT_W'(i) <= step) begin
            sticky_out = sticky_out | guard_out;
            guard_out  = mag_out[0];
            mag_out    = mag_out >> 1;
         end
      end
   end

endmodule

// File: rtl/fp32_to_int32.sv
// Multi-cycle FP32 to signed int32 converter with valid/ready on both sides.
// Build option: define FP32_TO_INT_RNE_EN for round-to-nearest-even; default truncates.
module fp32_to_int32
   import fp32_pkg::*;
#(
   parameter int SHIFT_STEP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_exception,
   output logic        out_overflow,
   output logic        out_inexact
);

   localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(SHIFT_STEP);

   function automatic logic [MAG_W:0] round_mag(input logic [MAG_W-1:0] m, input logic up);
      return {1'b0, m} + (MAG_W+1)'(up);
   endfunction

   // Returns {overflow, result}; only a positive 2^31 is unrepresentable here.
   function automatic logic [MAG_W:0] sat_result(input logic sgn, input logic [MAG_W:0] rmag);
      logic signed [MAG_W-1:0] neg;
      if (!sgn && (rmag[MAG_W] | rmag[MAG_W-1]))
         return {1'b1, 32'h7FFF_FFFF};
      neg = -$signed(rmag[MAG_W-1:0]);
      return {1'b0, sgn ? neg : rmag[MAG_W-1:0]};
   endfunction

   state_t state, state_nx;

   logic [EXP_W-1:0]        in_exp;
   logic [FRAC_W-1:0]       in_frac;
   logic signed [EXP_W:0]   in_e;
   logic                    in_exc, in_big, in_min, in_special, accept;
   logic [CNT_W-1:0]        in_count, count, count_nx, step;
   logic [MAG_W-1:0]        mag, sh_mag;
   logic                    sign, guard, sticky, sh_guard, sh_sticky;
   logic                    exc_q, ovf_q, min_q, rnd_up;
   logic [MAG_W:0]          rmag, sat;

   assign in_exp     = in_data[EXP_LSB +: EXP_W];
   assign in_frac    = in_data[FRAC_W-1:0];
   assign in_e       = $signed({1'b0, in_exp}) - $signed((EXP_W+1)'(FP32_BIAS));
   assign in_exc     = (in_exp == FP32_EXP_SPECIAL);
   assign in_big     = (in_e >= 9'sd31);
   assign in_min     = in_data[SIGN_BIT] & (in_exp == 8'd158) & (in_frac == '0);
   assign in_special = in_exc | in_big;
   // For e in [-1,30] the 6-bit wrap of 31-e yields the exact 1..32 distance.
   assign in_count   = in_special ? '0 :
                       (in_e <= -9'sd2) ? CNT_FLUSH : (6'd31 - in_e[CNT_W-1:0]);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid & in_ready;

   assign step     = (count < STEP_MAX) ? count : STEP_MAX;
   assign count_nx = count - step;

   fp_shift_sticky #(.SHIFT_STEP(SHIFT_STEP)) u_shift (
      .mag_in     (mag),
      .guard_in   (guard),
      .sticky_in  (sticky),
      .step       (step),
      .mag_out    (sh_mag),
      .guard_out  (sh_guard),
      .sticky_out (sh_sticky)
   );

`ifdef FP32_TO_INT_RNE_EN
   assign rnd_up = guard & (sticky | mag[0]);
`else
   assign rnd_up = 1'b0;
`endif

   assign rmag = round_mag(mag, rnd_up);
   assign sat  = sat_result(sign, rmag);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = in_special ? FINISH : SHIFT;
         SHIFT:   if (count_nx == '0) state_nx = FINISH;
         FINISH:  state_nx = HOLD;
         HOLD:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---- stage p0: operand capture and serial denormalisation
   always_ff @(posedge clk) begin
      if (accept) begin
         sign   <= in_data[SIGN_BIT];
         mag    <= {|in_exp, in_frac, (MAG_W-FRAC_W-1)'(0)};
         guard  <= 1'b0;
         sticky <= 1'b0;
         exc_q  <= in_exc;
         ovf_q  <= in_big & ~in_exc & ~in_min;
         min_q  <= in_min;
      end else if (state == SHIFT) begin
         mag    <= sh_mag;
         guard  <= sh_guard;
         sticky <= sh_sticky;
      end
   end

   // ---- stage p1: shift count and registered result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count         <= '0;
         out_data      <= '0;
         out_exception <= 1'b0;
         out_overflow  <= 1'b0;
         out_inexact   <= 1'b0;
      end else begin
         if (accept)              count <= in_count;
         else if (state == SHIFT) count <= count_nx;

         if (state == FINISH) begin
            if (exc_q) begin
               out_data      <= 32'hFFFF_FFFF;
               out_exception <= 1'b1;
               out_overflow  <= 1'b0;
               out_inexact   <= 1'b0;
            end else if (min_q) begin
               out_data      <= 32'h8000_0000;
               out_exception <= 1'b0;
               out_overflow  <= 1'b0;
               out_inexact   <= 1'b0;
            end else if (ovf_q) begin
               out_data      <= sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
               out_exception <= 1'b0;
               out_overflow  <= 1'b1;
               out_inexact   <= 1'b0;
            end else begin
               out_data      <= sat[MAG_W-1:0];
               out_exception <= 1'b0;
               out_overflow  <= sat[MAG_W];
               out_inexact   <= guard | sticky;
            end
         end
      end
   end

endmodule

// File: tb/tb_fp32_to_int32.sv
// Directed bench for fp32_to_int32 with an arithmetic reference model and per-cycle compare.
module tb_fp32_to_int32;

   localparam int SHIFT_STEP = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_exception, out_overflow, out_inexact;

   fp32_to_int32 #(.SHIFT_STEP(SHIFT_STEP)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_exception (out_exception),
      .out_overflow  (out_overflow),
      .out_inexact   (out_inexact)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] din;
      logic [31:0] data;
      logic        exc;
      logic        ovf;
      logic        inx;
      int          lat;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   acc_cyc = 0;
   bit   busy   = 0;
   bit   seen   = 0;
   exp_t exp_q[$];

   always @(posedge clk) cyc++;

   // Value = {hidden,frac} * 2^(e-23); integer part and remainder by plain division by 2^sh.
   function automatic exp_t model(input logic [31:0] v);
      exp_t        r;
      int          ex, e, sh, cnt;
      logic [63:0] sig, ip, rem, half;
      r.din = v; r.data = '0; r.exc = 0; r.ovf = 0; r.inx = 0;
      ex  = int'(v[30:23]);
      e   = ex - 127;
      cnt = 0;
      if (ex == 255) begin
         r.data = 32'hFFFF_FFFF;
         r.exc  = 1;
      end else if (e >= 31) begin
         if (v[31] && e == 31 && v[22:0] == 0) r.data = 32'h8000_0000;
         else begin
            r.ovf  = 1;
            r.data = v[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         end
      end else begin
         cnt = (e <= -2) ? 33 : 31 - e;
         sig = (ex != 0) ? (64'h80_0000 | 64'(v[22:0])) : 64'(v[22:0]);
         sh  = 23 - e;
         if (sh <= 0) begin
            ip = sig << (-sh); rem = 0; half = 1;
         end else if (sh >= 40) begin
            ip = 0; rem = sig; half = 64'h1 << 40;
         end else begin
            ip   = sig >> sh;
            rem  = sig & ((64'h1 << sh) - 1);
            half = 64'h1 << (sh - 1);
         end
`ifdef FP32_TO_INT_RNE_EN
         if (rem > half || (rem == half && ip[0])) ip = ip + 1;
`endif
         r.inx = (rem != 0);
         if (!v[31] && ip > 64'd2147483647) begin
            r.ovf  = 1;
            r.data = 32'h7FFF_FFFF;
         end else begin
            r.data = v[31] ? 32'(-ip) : ip[31:0];
         end
      end
      r.lat = 2 + (cnt + SHIFT_STEP - 1) / SHIFT_STEP;
      return r;
   endfunction

   task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL pin_%s model=%h expected=%h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         exp_q.delete();
         busy = 0;
         seen = 0;
      end else begin
         checks++;
         if (in_ready !== !busy) begin
            errors++;
            $display("FAIL in_ready got=%b want=%b cyc=%0d", in_ready, !busy, cyc);
         end
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_valid got out_data=%h want no result", out_data);
            end else begin
               e = exp_q[0];
               if (!seen) begin
                  checks++;
                  if (cyc - acc_cyc != e.lat) begin
                     errors++;
                     $display("FAIL latency in=%h got=%0d want=%0d", e.din, cyc - acc_cyc, e.lat);
                  end
                  seen = 1;
               end
               checks++;
               if (out_data !== e.data || out_exception !== e.exc ||
                   out_overflow !== e.ovf || out_inexact !== e.inx) begin
                  errors++;
                  $display("FAIL result in=%h got data=%h exc=%b ovf=%b inx=%b want data=%h exc=%b ovf=%b inx=%b",
                           e.din, out_data, out_exception, out_overflow, out_inexact,
                           e.data, e.exc, e.ovf, e.inx);
               end
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  busy = 0;
                  seen = 0;
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_data));
            acc_cyc = cyc;
            busy    = 1;
         end
      end
   end

   task automatic run(input logic [31:0] v, input int hold);
      int t;
      out_ready = (hold == 0);
      t = 0;
      while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
      in_valid = 1; in_data = v;
      @(posedge clk); #1;
      in_valid = 0;
      t = 0;
      while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL timeout in=%h got no out_valid want result", v);
      end
      repeat (hold) @(posedge clk);
      #1 out_ready = 1;
      @(posedge clk); #1;
   endtask

   logic [31:0] vecs [16];
   int          holds [16];
   exp_t        m;

   initial begin
      rst = 1; in_valid = 0; in_data = '0; out_ready = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      checks++;
      if ({out_data, out_exception, out_overflow, out_inexact} !== '0) begin
         errors++;
         $display("FAIL reset_out got data=%h flags=%b%b%b want 0", out_data,
                  out_exception, out_overflow, out_inexact);
      end

      m = model(32'h42F6_E666); pin("123p45_data", m.data, 32'd123);
      pin("123p45_inx", 32'(m.inx), 32'd1); pin("123p45_lat", 32'(m.lat), 32'd27);
      m = model(32'hC020_0000); pin("m2p5", m.data, 32'hFFFF_FFFE);
      m = model(32'h4F00_0000); pin("p2e31", {m.ovf, m.data[30:0]}, 32'hFFFF_FFFF);
      m = model(32'hCF00_0000); pin("m2e31", {m.ovf, m.data[30:0]}, 32'h0000_0000);
      m = model(32'h7F80_0000); pin("inf", {m.exc, m.data[30:0]}, 32'hFFFF_FFFF);
      pin("inf_lat", 32'(m.lat), 32'd2);
      m = model(32'h0000_0001); pin("denorm", {m.inx, m.data[30:0]}, 32'h8000_0000);
      m = model(32'h3FC0_0000);
`ifdef FP32_TO_INT_RNE_EN
      pin("1p5", m.data, 32'd2);
`else
      pin("1p5", m.data, 32'd1);
`endif

      vecs = '{32'h42F6_E666, 32'hC020_0000, 32'h4F00_0000, 32'hCF00_0000,
               32'h7F80_0000, 32'h0000_0001, 32'h3F80_0000, 32'hBF80_0000,
               32'h8000_0000, 32'h3FC0_0000, 32'h3F00_0000, 32'h3F7F_FFFF,
               32'h4EFF_FFFF, 32'h7FC0_0000, 32'h3E80_0000, 32'hCF80_0000};
      holds = '{0, 5, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1};
      foreach (vecs[i]) run(vecs[i], holds[i]);

      // Abort a conversion mid-shift; no result may follow.
      out_ready = 1;
      in_valid = 1; in_data = 32'h3F80_0000;
      @(posedge clk); #1 in_valid = 0;
      repeat (5) @(posedge clk);
      #2 rst = 1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_rst got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      @(posedge clk); #2 rst = 0;
      repeat (40) @(posedge clk);
      #1;
      run(32'h4B00_0001, 0);
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
